mem_stage: RTL

Memory-access pipeline stage sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the registered EX results plus a memory-operation descriptor, performs loads and stores over a simple request/ready data bus, and aligns and extends load data. It raises a stall request while a transaction is outstanding and forwards the final write-back triple downstream.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a request/ready bus,
// stalls upstream while a transaction is outstanding, and formats load data for write-back.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  in_wd,
   input  logic        in_wreg,
   input  logic [31:0] in_wdata,
   input  logic [3:0]  in_mem_op,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_mem_sdata,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        stall_req,
   output logic        addr_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   function automatic logic is_mem_op(input logic [3:0] op);
      is_mem_op = (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_store_op(input logic [3:0] op);
      is_store_op = (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: misaligned = a[0];
         OP_LW, OP_SW:         misaligned = |a;
         default:              misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_LB, OP_LBU, OP_SB: byte_enables = 4'b0001 << a;
         OP_LH, OP_LHU, OP_SH: byte_enables = a[1] ? 4'b1100 : 4'b0011;
         default:              byte_enables = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] sd);
      case (op)
         OP_SB:   store_lanes = {4{sd[7:0]}};
         OP_SH:   store_lanes = {2{sd[15:0]}};
         default: store_lanes = sd;
      endcase
   endfunction

   // Lane select, then sign or zero extension depending on the load flavour.
   function automatic logic [31:0] load_format(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] rd);
      logic        [7:0]  b;
      logic        [15:0] h;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      b  = rd[{lane, 3'b000} +: 8];
      h  = lane[1] ? rd[31:16] : rd[15:0];
      sb = b;
      sh = h;
      case (op)
         OP_LB:   load_format = 32'(sb);
         OP_LBU:  load_format = {24'd0, b};
         OP_LH:   load_format = 32'(sh);
         OP_LHU:  load_format = {16'd0, h};
         OP_LW:   load_format = rd;
         default: load_format = 32'd0;
      endcase
   endfunction

   state_t      state;
   logic        req_we_p1;
   logic [31:0] req_addr_p1;
   logic [3:0]  req_be_p1;
   logic [31:0] req_wdata_p1;
   logic [3:0]  req_op_p1;
   logic [1:0]  req_lane_p1;
   logic [4:0]  req_wd_p1;
   logic        req_wreg_p1;
   logic [31:0] rdata_p2;

   logic in_is_mem;
   logic in_misal;
   logic issue;

   assign in_is_mem = is_mem_op(in_mem_op);
   assign in_misal  = misaligned(in_mem_op, in_mem_addr[1:0]);
   assign issue     = (state == IDLE) && in_is_mem && !in_misal;

   // Control state and bus request fields (cleared on reset).
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         req_we_p1    <= 1'b0;
         req_addr_p1  <= 32'd0;
         req_be_p1    <= 4'd0;
         req_wdata_p1 <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state        <= REQ;
                  req_we_p1    <= is_store_op(in_mem_op);
                  req_addr_p1  <= {in_mem_addr[31:2], 2'b00};
                  req_be_p1    <= byte_enables(in_mem_op, in_mem_addr[1:0]);
                  req_wdata_p1 <= store_lanes(in_mem_op, in_mem_sdata);
               end
            end
            REQ:     if (bus_ready) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write-back payload; only consumed in DONE, so no reset needed.
   always_ff @(posedge clk) begin
      if (issue) begin
         req_op_p1   <= in_mem_op;
         req_lane_p1 <= in_mem_addr[1:0];
         req_wd_p1   <= in_wd;
         req_wreg_p1 <= in_wreg;
      end
      if ((state == REQ) && bus_ready) rdata_p2 <= bus_rdata;
   end

   always_comb begin
      wb_wd     = 5'd0;
      wb_wreg   = 1'b0;
      wb_wdata  = 32'd0;
      stall_req = 1'b0;
      addr_err  = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'd0;
      bus_be    = 4'd0;
      bus_wdata = 32'd0;
      if (!rst) begin
         case (state)
            IDLE: begin
               wb_wd    = in_wd;
               wb_wdata = in_wdata;
               if (!in_is_mem) begin
                  wb_wreg = in_wreg;
               end else if (in_misal) begin
                  addr_err = 1'b1;
               end else begin
                  stall_req = 1'b1;
               end
            end
            REQ: begin
               wb_wd     = req_wd_p1;
               stall_req = 1'b1;
               bus_req   = 1'b1;
               bus_we    = req_we_p1;
               bus_addr  = req_addr_p1;
               bus_be    = req_be_p1;
               bus_wdata = req_wdata_p1;
            end
            DONE: begin
               wb_wd = req_wd_p1;
               if (!is_store_op(req_op_p1)) begin
                  wb_wreg  = req_wreg_p1;
                  wb_wdata = load_format(req_op_p1, req_lane_p1, rdata_p2);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
